// File: rtl/johnson_tdm_arbiter.sv
// rtl/johnson_tdm_arbiter.sv - four-requester TDM arbiter timed by a self-correcting 16-phase Johnson ring
module johnson_tdm_arbiter #(
    parameter logic [31:0] SLOT_MAP      = 32'hE4E4E4E4,
    parameter bit          WORK_CONSERVE = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       EN,
    input  logic       LOAD,
    input  logic [3:0] LOAD_IDX,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic [1:0] GNT_ID,
    output logic       GNT_VALID,
    output logic [7:0] PHASE,
    output logic [3:0] PHASE_IDX,
    output logic       SYNC,
    output logic       ERR
);

    logic [7:0] phase_q, phase_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       err_q, err_d;

    logic       legal;
    logic [3:0] phase_idx;
    logic [1:0] owner;
    logic [1:0] cand;
    logic       found;

    function automatic logic [7:0] code_of(input logic [3:0] k);
        case (k)
            4'd0:    code_of = 8'h00;
            4'd1:    code_of = 8'h01;
            4'd2:    code_of = 8'h03;
            4'd3:    code_of = 8'h07;
            4'd4:    code_of = 8'h0F;
            4'd5:    code_of = 8'h1F;
            4'd6:    code_of = 8'h3F;
            4'd7:    code_of = 8'h7F;
            4'd8:    code_of = 8'hFF;
            4'd9:    code_of = 8'hFE;
            4'd10:   code_of = 8'hFC;
            4'd11:   code_of = 8'hF8;
            4'd12:   code_of = 8'hF0;
            4'd13:   code_of = 8'hE0;
            4'd14:   code_of = 8'hC0;
            default: code_of = 8'h80;
        endcase
    endfunction

    // Illegal codes decode to index 0 with legal low.
    always_comb begin
        legal     = 1'b0;
        phase_idx = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (phase_q == code_of(4'(k))) begin
                legal     = 1'b1;
                phase_idx = 4'(k);
            end
        end
    end

    assign owner = SLOT_MAP[{phase_idx, 1'b0} +: 2];

    always_comb begin
        phase_d     = phase_q;
        err_d       = 1'b0;
        gnt_d       = 4'd0;
        gnt_id_d    = 2'd0;
        gnt_valid_d = 1'b0;
        found       = 1'b0;
        cand        = 2'd0;
        if (!legal) begin
            phase_d = 8'h00;
            err_d   = 1'b1;
        end else begin
            if (EN) begin
                if (REQ[owner]) begin
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = owner;
                end else if (WORK_CONSERVE && (REQ != 4'd0)) begin
                    // Round-robin handoff starts just after the slot owner.
                    for (int i = 1; i < 4; i++) begin
                        cand = owner + 2'(i);
                        if (!found && REQ[cand]) begin
                            found       = 1'b1;
                            gnt_valid_d = 1'b1;
                            gnt_id_d    = cand;
                        end
                    end
                end
            end
            if (LOAD) begin
                phase_d = code_of(LOAD_IDX);
            end else if (EN) begin
                phase_d = {phase_q[6:0], ~phase_q[7]};
            end
        end
        if (gnt_valid_d) begin
            gnt_d = 4'd1 << gnt_id_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            phase_q     <= 8'h00;
            gnt_q       <= 4'd0;
            gnt_id_q    <= 2'd0;
            gnt_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            err_q       <= err_d;
        end
    end

    assign PHASE     = phase_q;
    assign PHASE_IDX = phase_idx;
    assign SYNC      = (phase_q == 8'h00);
    assign GNT       = gnt_q;
    assign GNT_ID    = gnt_id_q;
    assign GNT_VALID = gnt_valid_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_johnson_tdm_arbiter.sv
// tb/tb_johnson_tdm_arbiter.sv - directed and random checks of johnson_tdm_arbiter against a slot-table model
module tb_johnson_tdm_arbiter;

    localparam logic [31:0] MAP = 32'hE4E4E4E4;

    logic       clk = 1'b0;
    logic       reset, en, load;
    logic [3:0] load_idx, req;

    logic [3:0] gnt, nc_gnt;
    logic [1:0] gnt_id, nc_gnt_id;
    logic       gnt_valid, nc_gnt_valid;
    logic [7:0] phase, nc_phase;
    logic [3:0] phase_idx, nc_phase_idx;
    logic       sync, nc_sync, err, nc_err;

    int compared = 0;
    int mismatched = 0;

    int m_idx;
    bit m_legal;
    bit m_err;
    bit m_v, m_nc_v;
    int m_id, m_nc_id;

    johnson_tdm_arbiter #(.SLOT_MAP(MAP), .WORK_CONSERVE(1'b1)) dut (
        .CLK(clk), .RESET(reset), .EN(en), .LOAD(load), .LOAD_IDX(load_idx), .REQ(req),
        .GNT(gnt), .GNT_ID(gnt_id), .GNT_VALID(gnt_valid), .PHASE(phase),
        .PHASE_IDX(phase_idx), .SYNC(sync), .ERR(err)
    );

    johnson_tdm_arbiter #(.SLOT_MAP(MAP), .WORK_CONSERVE(1'b0)) dut_nc (
        .CLK(clk), .RESET(reset), .EN(en), .LOAD(load), .LOAD_IDX(load_idx), .REQ(req),
        .GNT(nc_gnt), .GNT_ID(nc_gnt_id), .GNT_VALID(nc_gnt_valid), .PHASE(nc_phase),
        .PHASE_IDX(nc_phase_idx), .SYNC(nc_sync), .ERR(nc_err)
    );

    always #5 clk = ~clk;

    // Johnson code for index k: k ones filling from the LSB, then zeros filling from the LSB.
    function automatic logic [7:0] jcode(input int k);
        if (k <= 8) return 8'((1 << k) - 1);
        return 8'((32'hFF << (k - 8)) & 32'hFF);
    endfunction

    function automatic int owner_of(input int k);
        return int'((MAP >> (2 * k)) & 32'h3);
    endfunction

    task automatic arb(input int k, input logic [3:0] r, input bit wc,
                       output bit v, output int id);
        int o;
        o  = owner_of(k);
        v  = 1'b0;
        id = 0;
        if (r[o]) begin
            v  = 1'b1;
            id = o;
        end else if (wc) begin
            for (int j = 1; j < 4; j++) begin
                if (!v && r[(o + j) % 4]) begin
                    v  = 1'b1;
                    id = (o + j) % 4;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0] eg, eng;
        eg  = m_v ? 4'(1 << m_id) : 4'd0;
        eng = m_nc_v ? 4'(1 << m_nc_id) : 4'd0;
        chk("phase", phase, jcode(m_idx));
        chk("phase_idx", phase_idx, m_idx);
        chk("sync", sync, m_idx == 0);
        chk("gnt", gnt, eg);
        chk("gnt_id", gnt_id, m_v ? m_id : 0);
        chk("gnt_valid", gnt_valid, m_v);
        chk("err", err, m_err);
        chk("nc_gnt", nc_gnt, eng);
        chk("nc_phase", nc_phase, jcode(m_idx));
    endtask

    task automatic step(input bit rst, input bit e, input bit ld, input int li, input logic [3:0] r);
        bit v, nv;
        int id, nid;
        @(negedge clk);
        reset = rst; en = e; load = ld; load_idx = li[3:0]; req = r;
        if (rst) begin
            m_idx = 0; m_legal = 1'b1; m_err = 1'b0; m_v = 1'b0; m_nc_v = 1'b0;
        end else if (!m_legal) begin
            m_idx = 0; m_legal = 1'b1; m_err = 1'b1; m_v = 1'b0; m_nc_v = 1'b0;
        end else begin
            v = 1'b0; nv = 1'b0; id = 0; nid = 0;
            if (e) begin
                arb(m_idx, r, 1'b1, v, id);
                arb(m_idx, r, 1'b0, nv, nid);
            end
            m_v = v; m_id = id; m_nc_v = nv; m_nc_id = nid;
            m_err = 1'b0;
            if (ld) m_idx = li % 16;
            else if (e) m_idx = (m_idx + 1) % 16;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Writes the ring register directly to emulate an upset.
    task automatic deposit(input logic [7:0] val);
        dut.phase_q    = val;
        dut_nc.phase_q = val;
        m_legal = 1'b0;
        m_idx   = 0;
        for (int k = 0; k < 16; k++) begin
            if (jcode(k) == val) begin
                m_legal = 1'b1;
                m_idx   = k;
            end
        end
        #1;
        chk("dep_phase", phase, val);
        chk("dep_idx", phase_idx, m_idx);
        chk("dep_sync", sync, val == 8'h00);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; load = 1'b0; load_idx = 4'd0; req = 4'd0;
        m_idx = 0; m_legal = 1'b1; m_err = 1'b0; m_v = 1'b0; m_nc_v = 1'b0; m_id = 0; m_nc_id = 0;

        step(1, 0, 0, 0, 4'h0);
        step(1, 1, 1, 7, 4'hF);
        chk("reset_phase", phase, 8'h00);
        chk("reset_sync", sync, 1'b1);

        for (int i = 0; i < 17; i++) step(0, 1, 0, 0, 4'h0);
        chk("wrap_phase", phase, 8'h01);

        step(1, 0, 0, 0, 4'h0);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 4'hF);

        step(1, 0, 0, 0, 4'h0);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 4'h4);

        step(1, 0, 0, 0, 4'h0);
        step(0, 1, 0, 0, 4'hA);
        chk("handoff_gnt", gnt, 4'b0010);
        step(0, 1, 0, 0, 4'h0);
        step(0, 1, 0, 0, 4'h0);
        step(0, 1, 0, 0, 4'h1);
        chk("wrap_search_gnt", gnt, 4'b0001);

        step(1, 0, 0, 0, 4'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 4'hF);
        step(0, 1, 1, 9, 4'hF);
        chk("load_phase", phase, 8'hFE);
        chk("load_gnt", gnt, 4'b0001);
        step(0, 1, 0, 0, 4'hF);
        chk("after_load", phase, 8'hFC);

        deposit(8'h5A);
        step(0, 1, 1, 5, 4'hF);
        chk("corr_err", err, 1'b1);
        step(0, 1, 0, 0, 4'hF);
        step(1, 1, 0, 0, 4'hF);
        chk("reset_gnt", gnt, 4'd0);

        step(0, 0, 0, 0, 4'hF);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) deposit(8'($urandom));
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)),
                 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
